fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Code-fetch sequencer and memory-port arbiter for the CPU front end.
- Accepts burst-fetch requests from the decode buffer and tracks the fetch address, which is reloaded on jumps.
- Issues 64-bit word reads on the shared memory port and writes the returned words into the prefetch queue RAM.
- Shares the port with execution-unit data accesses; data wins at every word boundary.

Parameters:
- BURST, 4, number of 64-bit words fetched per fetch request (1..15).
- AW, 20, linear address width in bits.

Ports:
- iClk  in  1  clock
- iRst  in  1  reset
- iFetchReq  in  1  one-cycle pulse from decode buffer: fetch one burst
- iJump  in  1  one-cycle pulse: flow change
- iJumpAdr  in  AW  new linear code address, sampled with iJump
- oAckWr  out  1  pulse: oWrData is valid and is written to queue this cycle
- oWrData  out  64  fetched code word
- oMemIndex  out  3  byte offset of first valid byte; meaningful only with the first oAckWr after a jump, else 0
- oAckCnt  out  1  high while a fetch burst is in progress
- iDReq  in  1  data access request, held until oDAck
- iDWe  in  1  1 = write
- iDAdr  in  AW-3  data word address
- iDWData  in  64  write data
- oDAck  out  1  pulse: data access complete
- oDRData  out  64  read data, valid with oDAck
- oMReq  out  1  memory transaction request, held until iMAck
- oMWe  out  1  write enable
- oMAdr  out  AW-3  word address
- oMWData  out  64  write data
- iMAck  in  1  pulse: transaction complete; iMData valid for reads
- iMData  in  64  read data

Behaviour:
- Reset: iRst, synchronous, active-high; clock iClk (rising edge).
  - All outputs 0; FAdr = 0; state IDLE; pending = 0; cnt = 0; firstIdx = 0; drop = 0.
- State machine: IDLE, FETCH, DATA. Only one memory transaction is outstanding at any time.
- IDLE:
  - iDReq -> DATA.
  - Otherwise (pending | iFetchReq) & ~iJump -> FETCH.
  - Entering FETCH from IDLE with no burst in progress: cnt = BURST; oAckCnt <= 1; pending cleared.
- FETCH: oMReq=1, oMWe=0, oMAdr=FAdr. On iMAck:
  - If drop=0: oAckWr pulse with oWrData=iMData; oMemIndex=firstIdx, then firstIdx <= 0.
  - FAdr <= FAdr+1, wrapping modulo 2^(AW-3); cnt <= cnt-1.
  - If cnt reaches 0 or drop=1: oAckCnt <= 0, drop <= 0, go to IDLE.
  - Otherwise: if iDReq go to DATA (burst suspended, oAckCnt stays 1), else stay in FETCH.
- DATA: oMReq=1, oMWe=iDWe, oMAdr=iDAdr, oMWData=iDWData.
  - On iMAck: oDAck pulse; oDRData=iMData (write: don't-care).
  - Then resume FETCH if cnt != 0, else IDLE.
- Latency:
  - oMReq asserts in the cycle after the iFetchReq edge.
  - oAckWr and oDAck assert in the cycle after iMAck (registered).
  - oMReq drops in the cycle after iMAck, one idle cycle minimum between transactions.
- iFetchReq while a burst is in progress: set pending (one deep; further pulses lost). Pending starts a new burst when the current burst ends.
- iJump:
  - FAdr <= iJumpAdr[AW-1:3]; firstIdx <= iJumpAdr[2:0]; pending <= 0; cnt <= 0.
  - If a FETCH transaction is outstanding (oMReq=1): drop <= 1. The transaction still completes, its data is discarded (no oAckWr), and oAckCnt falls on that iMAck.
  - Otherwise oAckCnt <= 0 immediately.
  - A DATA transaction in flight is unaffected; it returns to IDLE since cnt=0.
- iJump and iFetchReq in the same cycle: the jump applies and the request is ignored. The decode buffer re-requests.
- iJump coincident with fetch iMAck: the word is dropped; FAdr takes the jump value, not the increment.
- oAckCnt always produces a falling edge at burst end or abort. The decode buffer relies on this edge to re-arm.
- iRst mid-transaction: the state is abandoned. The memory side must also be reset.

Test Plan:
- Reset, then iFetchReq at address 0 with iMAck 2 cycles after each oMReq -> oMAdr 0,1,2,3; four oAckWr with matching data; oAckCnt 1→0 after the 4th word.
- iJump to 0x01235, then iFetchReq -> first oMAdr=0x0246, first oAckWr has oMemIndex=5, later ones 0.
- Data write requested during word 2 of a burst -> DATA runs after word 2 (oDAck, oMWe=1); fetch resumes at word 3; oAckCnt stays 1 throughout.
- iJump while a fetch is outstanding -> no oAckWr for that beat; oAckCnt falls on its iMAck; next burst starts at the jump address.
- iFetchReq pulsed twice during a burst -> exactly one extra burst of 4 follows.
- FAdr=0x1FFFF, BURST=4 -> oMAdr 0x1FFFF, 0x00000, 0x00001, 0x00002.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl_if
// Brief    : Shared memory-port bundle between the fetch controller (master)
//            and the external memory (slave). One transaction is held with
//            mreq until the memory answers with a one-cycle mack.
// Revision : 1.0  initial release
// ============================================================================
interface fetch_ctrl_if #(
  parameter int AW = 20
);
  logic          mreq;    // transaction request, held until mack
  logic          mwe;     // 1 = write
  logic [AW-4:0] madr;    // 64-bit word address
  logic [63:0]   mwdata;  // write data
  logic          mack;    // one-cycle completion pulse
  logic [63:0]   mdata;   // read data, valid with mack

  modport master (
    output mreq, mwe, madr, mwdata,
    input  mack, mdata
  );

  modport slave (
    input  mreq, mwe, madr, mwdata,
    output mack, mdata
  );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Code-fetch sequencer and memory-port arbiter. Fetches bursts of
//            64-bit code words into the prefetch queue and shares the memory
//            port with execution-unit data accesses, which win at every word
//            boundary.
// Revision : 1.0  initial release
// ============================================================================
module fetch_ctrl #(
  parameter int BURST = 4,
  parameter int AW    = 20
) (
  input  logic          iClk,
  input  logic          iRst,
  // decode buffer side
  input  logic          iFetchReq,
  input  logic          iJump,
  input  logic [AW-1:0] iJumpAdr,
  output logic          oAckWr,
  output logic [63:0]   oWrData,
  output logic [2:0]    oMemIndex,
  output logic          oAckCnt,
  // execution-unit data side
  input  logic          iDReq,
  input  logic          iDWe,
  input  logic [AW-4:0] iDAdr,
  input  logic [63:0]   iDWData,
  output logic          oDAck,
  output logic [63:0]   oDRData,
  // shared memory port
  fetch_ctrl_if.master  mem
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;

  logic [AW-4:0] fadr;       // next code word address
  logic [2:0]    first_idx;  // byte offset reported with the first word after a jump
  logic [3:0]    cnt;        // words still to fetch in the current burst
  logic          pending;    // one-deep queued fetch request
  logic          drop;       // outstanding fetch was overtaken by a jump
  logic          gap;        // forces one idle cycle after every transaction

  logic          req_active;
  logic          macked;
  logic          start_burst;
  logic          word_ok;
  logic          fetch_end;
  logic          data_done;

  // State register
  always_ff @(posedge iClk) begin
    if (iRst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state decode and memory-port drive
  always_comb begin
    state_nx    = state;
    start_burst = 1'b0;
    word_ok     = 1'b0;
    fetch_end   = 1'b0;
    data_done   = 1'b0;
    req_active  = (state != IDLE) && !gap;
    macked      = req_active && mem.mack;
    mem.mreq    = req_active;
    mem.mwe     = 1'b0;
    mem.madr    = '0;
    mem.mwdata  = '0;

    case (state)
      IDLE: begin
        if (iDReq) begin
          state_nx = DATA;
        end else if ((pending || iFetchReq) && !iJump) begin
          state_nx    = FETCH;
          start_burst = 1'b1;
        end
      end

      FETCH: begin
        mem.madr = fadr;
        if (macked) begin
          // A coincident jump discards the word just like an earlier one.
          if (drop || iJump) begin
            fetch_end = 1'b1;
            state_nx  = IDLE;
          end else begin
            word_ok = 1'b1;
            if (cnt == 4'd1) begin
              fetch_end = 1'b1;
              state_nx  = IDLE;
            end else if (iDReq) begin
              state_nx = DATA;
            end
          end
        end else if (iJump && !req_active) begin
          // Jump between beats: nothing in flight, abort right away.
          state_nx = IDLE;
        end
      end

      DATA: begin
        mem.mwe    = iDWe;
        mem.madr   = iDAdr;
        mem.mwdata = iDWData;
        if (macked) begin
          data_done = 1'b1;
          state_nx  = (cnt != 4'd0 && !iJump) ? FETCH : IDLE;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // Fetch address, burst bookkeeping and registered handshake outputs
  always_ff @(posedge iClk) begin
    if (iRst) begin
      fadr      <= '0;
      first_idx <= '0;
      cnt       <= '0;
      pending   <= 1'b0;
      drop      <= 1'b0;
      gap       <= 1'b0;
      oAckWr    <= 1'b0;
      oWrData   <= '0;
      oMemIndex <= '0;
      oAckCnt   <= 1'b0;
      oDAck     <= 1'b0;
      oDRData   <= '0;
    end else begin
      gap       <= macked;
      oAckWr    <= 1'b0;
      oMemIndex <= '0;
      oDAck     <= 1'b0;

      if (start_burst) begin
        cnt     <= 4'(BURST);
        oAckCnt <= 1'b1;
      end

      if (word_ok) begin
        oAckWr    <= 1'b1;
        oWrData   <= mem.mdata;
        oMemIndex <= first_idx;
        first_idx <= '0;
        fadr      <= fadr + 1'b1;
        cnt       <= cnt - 4'd1;
      end

      if (fetch_end) begin
        oAckCnt <= 1'b0;
        drop    <= 1'b0;
      end

      if (data_done) begin
        oDAck   <= 1'b1;
        oDRData <= mem.mdata;
      end

      // Requests seen while a burst cannot start now are remembered once.
      if (iJump || start_burst) pending <= 1'b0;
      else if (iFetchReq)       pending <= 1'b1;

      // A jump overrides every address/count update made above.
      if (iJump) begin
        fadr      <= iJumpAdr[AW-1:3];
        first_idx <= iJumpAdr[2:0];
        cnt       <= '0;
        if (state == FETCH && req_active && !mem.mack) drop <= 1'b1;
        else                                           oAckCnt <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Directed bench for fetch_ctrl: table of fetch bursts plus
//            hand-written multi-cycle sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_ctrl;
  localparam int AW    = 20;
  localparam int BURST = 4;
  localparam int NV    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req, jump;
  logic [AW-1:0] jump_adr;
  logic          ack_wr, ack_cnt;
  logic [63:0]   wr_data;
  logic [2:0]    mem_index;
  logic          d_req, d_we, d_ack;
  logic [AW-4:0] d_adr;
  logic [63:0]   d_wdata, d_rdata;

  fetch_ctrl_if #(.AW(AW)) mif();

  fetch_ctrl #(.BURST(BURST), .AW(AW)) dut (
    .iClk(clk), .iRst(rst),
    .iFetchReq(fetch_req), .iJump(jump), .iJumpAdr(jump_adr),
    .oAckWr(ack_wr), .oWrData(wr_data), .oMemIndex(mem_index), .oAckCnt(ack_cnt),
    .iDReq(d_req), .iDWe(d_we), .iDAdr(d_adr), .iDWData(d_wdata),
    .oDAck(d_ack), .oDRData(d_rdata),
    .mem(mif.master)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  // memory-side and queue-side logs
  logic [16:0] t_adr [128];
  logic        t_we  [128];
  logic [63:0] t_wd  [128];
  int          t_n = 0;
  int          m_acks = 0;
  logic [63:0] a_data [128];
  logic [2:0]  a_idx  [128];
  int          a_n = 0;
  int          d_n = 0;
  logic [63:0] d_last;
  int          falls = 0;
  int          fall_macks = 0;
  int          lat = 2;

  function automatic logic [63:0] mem_word(input logic [16:0] a);
    return {15'h1357, a, 15'h2468, ~a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_fetch();
    fetch_req = 1'b1;
    @(posedge clk); #1;
    fetch_req = 1'b0;
  endtask

  task automatic pulse_jump(input logic [AW-1:0] adr);
    jump = 1'b1; jump_adr = adr;
    @(posedge clk); #1;
    jump = 1'b0;
  endtask

  task automatic wait_falls(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (falls < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(falls >= target), 64'd1);
  endtask

  // Memory model: answers each request after 'lat' cycles
  initial begin
    logic [16:0] adr;
    logic        we;
    mif.mack = 1'b0; mif.mdata = '0;
    forever begin
      @(negedge clk);
      if (mif.mreq && !rst) begin
        adr = mif.madr; we = mif.mwe;
        if (t_n < 128) begin
          t_adr[t_n] = adr; t_we[t_n] = we; t_wd[t_n] = mif.mwdata;
        end
        t_n++;
        repeat (lat) @(negedge clk);
        mif.mack = 1'b1;
        mif.mdata = we ? 64'h0 : mem_word(adr);
        m_acks++;
        @(negedge clk);
        mif.mack = 1'b0; mif.mdata = '0;
      end
    end
  end

  // Output monitor
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ack_wr) begin
          if (a_n < 128) begin a_data[a_n] = wr_data; a_idx[a_n] = mem_index; end
          a_n++;
        end
        if (d_ack) begin d_n++; d_last = d_rdata; end
        if (prev && !ack_cnt) begin falls++; fall_macks = m_acks; end
        prev = ack_cnt;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct packed {
    logic            do_jump;
    logic [19:0]     jadr;
    logic [3:0][16:0] exp_adr;
    logic [2:0]      exp_idx;
  } vec_t;

  vec_t vecs [NV];

  initial begin
    int a0, t0, f0, d0, m0, n;
    vecs[0] = '{1'b0, 20'h00000, {17'h00003, 17'h00002, 17'h00001, 17'h00000}, 3'd0};
    vecs[1] = '{1'b1, 20'h01235, {17'h00249, 17'h00248, 17'h00247, 17'h00246}, 3'd5};
    vecs[2] = '{1'b0, 20'h00000, {17'h0024D, 17'h0024C, 17'h0024B, 17'h0024A}, 3'd0};
    vecs[3] = '{1'b1, 20'hFFFFF, {17'h00002, 17'h00001, 17'h00000, 17'h1FFFF}, 3'd7};
    vecs[4] = '{1'b1, 20'h00008, {17'h00004, 17'h00003, 17'h00002, 17'h00001}, 3'd0};

    rst = 1'b1; fetch_req = 0; jump = 0; jump_adr = '0;
    d_req = 0; d_we = 0; d_adr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_mreq", 64'(mif.mreq), 64'd0);
    check("rst_ackcnt", 64'(ack_cnt), 64'd0);
    check("rst_ackwr", 64'(ack_wr), 64'd0);
    check("rst_dack", 64'(d_ack), 64'd0);
    check("rst_madr", 64'(mif.madr), 64'd0);
    check("rst_memidx", 64'(mem_index), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // ---- table of plain bursts ----
    for (int v = 0; v < NV; v++) begin
      a0 = a_n; t0 = t_n; f0 = falls;
      if (vecs[v].do_jump) pulse_jump(vecs[v].jadr);
      pulse_fetch();
      @(negedge clk);
      check($sformatf("v%0d_req_latency", v), 64'(mif.mreq), 64'd1);
      wait_falls(f0 + 1, 100, $sformatf("v%0d_burst_end", v));
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_nwords", v), 64'(a_n - a0), 64'd4);
      check($sformatf("v%0d_ntrans", v), 64'(t_n - t0), 64'd4);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("v%0d_adr%0d", v, i), 64'(t_adr[t0+i]), 64'(vecs[v].exp_adr[i]));
        check($sformatf("v%0d_data%0d", v, i), a_data[a0+i], mem_word(vecs[v].exp_adr[i]));
        check($sformatf("v%0d_idx%0d", v, i), 64'(a_idx[a0+i]), (i == 0) ? 64'(vecs[v].exp_idx) : 64'd0);
      end
    end

    // ---- jump and fetch in the same cycle: request ignored ----
    t0 = t_n;
    jump = 1'b1; jump_adr = 20'h00028; fetch_req = 1'b1;
    @(posedge clk); #1;
    jump = 1'b0; fetch_req = 1'b0;
    repeat (20) @(negedge clk);
    check("jf_same_no_trans", 64'(t_n - t0), 64'd0);
    check("jf_same_ackcnt", 64'(ack_cnt), 64'd0);

    // ---- data read from idle ----
    t0 = t_n; d0 = d_n;
    d_req = 1'b1; d_we = 1'b0; d_adr = 17'h00333;
    n = 0;
    do begin @(negedge clk); n++; end while (!d_ack && n < 50);
    d_req = 1'b0;
    check("rd_dack_seen", 64'(d_ack), 64'd1);
    check("rd_data", d_rdata, mem_word(17'h00333));
    repeat (5) @(negedge clk);
    check("rd_one_trans", 64'(t_n - t0), 64'd1);
    check("rd_we", 64'(t_we[t0]), 64'd0);

    // ---- data write interleaved after word 2 ----
    a0 = a_n; t0 = t_n; f0 = falls; d0 = d_n;
    pulse_fetch();
    n = 0;
    while (t_n < t0 + 2 && n < 50) begin @(negedge clk); n++; end
    d_req = 1'b1; d_we = 1'b1; d_adr = 17'h00ABC; d_wdata = 64'h0123_4567_89AB_CDEF;
    n = 0;
    do begin @(negedge clk); n++; end while (!d_ack && n < 50);
    d_req = 1'b0; d_we = 1'b0;
    check("wr_dack_seen", 64'(d_ack), 64'd1);
    check("wr_ackcnt_held", 64'(ack_cnt), 64'd1);
    wait_falls(f0 + 1, 100, "wr_burst_end");
    repeat (3) @(negedge clk);
    check("wr_ntrans", 64'(t_n - t0), 64'd5);
    check("wr_adr0", 64'(t_adr[t0+0]), 64'h5);
    check("wr_adr1", 64'(t_adr[t0+1]), 64'h6);
    check("wr_adr_data", 64'(t_adr[t0+2]), 64'hABC);
    check("wr_we", 64'(t_we[t0+2]), 64'd1);
    check("wr_wdata", t_wd[t0+2], 64'h0123_4567_89AB_CDEF);
    check("wr_adr2", 64'(t_adr[t0+3]), 64'h7);
    check("wr_we_fetch", 64'(t_we[t0+3]), 64'd0);
    check("wr_adr3", 64'(t_adr[t0+4]), 64'h8);
    check("wr_nwords", 64'(a_n - a0), 64'd4);
    check("wr_nfalls", 64'(falls - f0), 64'd1);
    check("wr_ndack", 64'(d_n - d0), 64'd1);

    // ---- jump while a fetch is outstanding ----
    a0 = a_n; t0 = t_n; f0 = falls; m0 = m_acks;
    lat = 6;
    pulse_fetch();
    @(posedge clk); #1;
    pulse_jump(20'h00405);
    @(negedge clk);
    check("jo_ackcnt_held", 64'(ack_cnt), 64'd1);
    wait_falls(f0 + 1, 50, "jo_fall");
    check("jo_fall_on_ack", 64'(fall_macks - m0), 64'd1);
    repeat (3) @(negedge clk);
    check("jo_no_word", 64'(a_n - a0), 64'd0);
    check("jo_one_trans", 64'(t_n - t0), 64'd1);
    lat = 2;
    a0 = a_n; t0 = t_n; f0 = falls;
    pulse_fetch();
    wait_falls(f0 + 1, 100, "jo_next_end");
    repeat (3) @(negedge clk);
    check("jo_next_adr0", 64'(t_adr[t0]), 64'h80);
    check("jo_next_adr3", 64'(t_adr[t0+3]), 64'h83);
    check("jo_next_idx0", 64'(a_idx[a0]), 64'd5);
    check("jo_next_idx1", 64'(a_idx[a0+1]), 64'd0);

    // ---- two extra requests during a burst: exactly one more burst ----
    a0 = a_n; t0 = t_n; f0 = falls;
    pulse_fetch();
    repeat (2) @(posedge clk); #1;
    pulse_fetch();
    repeat (2) @(posedge clk); #1;
    pulse_fetch();
    wait_falls(f0 + 2, 200, "dbl_two_bursts");
    repeat (30) @(negedge clk);
    check("dbl_ntrans", 64'(t_n - t0), 64'd8);
    check("dbl_nwords", 64'(a_n - a0), 64'd8);
    check("dbl_nfalls", 64'(falls - f0), 64'd2);
    check("dbl_ackcnt_low", 64'(ack_cnt), 64'd0);
    for (int i = 0; i < 8; i++)
      check($sformatf("dbl_adr%0d", i), 64'(t_adr[t0+i]), 64'h84 + 64'(i));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
`default_nettype wire
